// File: rtl/nibble_addsub_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit:
// the controller state encoding and the slice width.
package nibble_addsub_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_addsub_seq_addsub4_slice.sv
// Combinational 4-bit add/subtract slice. When m=1, b is inverted so the
// caller can form A-B by feeding cin=1. c3 is the carry into bit 3, which the
// caller XORs with cout to get signed overflow on the top nibble.
module addsub4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] b_eff;
    logic [3:0] low_sum;
    logic [1:0] top_sum;

    assign b_eff = b ^ {4{m}};

    // The low three bits are summed separately so the carry into bit 3 is visible.
    assign low_sum = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};
    assign c3      = low_sum[3];
    assign top_sum = {1'b0, a[3]} + {1'b0, b_eff[3]} + {1'b0, c3};

    assign s    = {top_sum[0], low_sum[2:0]};
    assign cout = top_sum[1];

endmodule

// File: rtl/nibble_addsub_seq.sv
// Nibble-serial W-bit adder/subtractor. One 4-bit slice processes one nibble
// per clock, LSB first. After the last nibble there is one finalisation cycle
// in DONE before out_valid rises, so a result appears W/4+1 edges after accept.
// Optional feature: define NIBBLE_ADDSUB_SEQ_SAT_EN to replace an overflowed
// result with the signed saturation value during that finalisation cycle.
module nibble_addsub_seq
    import nibble_addsub_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         v
);

    localparam int NIBBLES = W / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  carry;
    logic signed [W-1:0]   a_lat;
    logic signed [W-1:0]   b_lat;
    logic                  m_lat;
    logic [W-1:0]          s_q;
    logic                  cout_q;
    logic                  v_q;
    logic                  out_valid_q;
    logic                  in_ready_q;

    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   sum_nib;
    logic                  slice_cout;
    logic                  slice_c3;
    logic                  accept;

`ifdef NIBBLE_ADDSUB_SEQ_SAT_EN
    // Largest positive value for a non-negative A, most negative otherwise.
    function automatic logic [W-1:0] sat_value(input logic a_sign);
        return a_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction
`endif

    assign accept = in_valid & in_ready_q;
    assign a_nib  = a_lat[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib  = b_lat[idx*NIBBLE_W +: NIBBLE_W];

    addsub4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .m    (m_lat),
        .cin  (carry),
        .s    (sum_nib),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    // Capture operands and mode on accept; held for the whole operation.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_lat <= a;
            b_lat <= b;
            m_lat <= m;
        end
    end

    // Controller: accept in IDLE, one nibble per RUN cycle, finalise and hand off in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry      <= m;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    s_q[idx*NIBBLE_W +: NIBBLE_W] <= sum_nib;
                    carry <= slice_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout_q <= slice_cout;
                        v_q    <= slice_cout ^ slice_c3;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
`ifdef NIBBLE_ADDSUB_SEQ_SAT_EN
                        if (v_q) begin
                            s_q <= sat_value(a_lat[W-1]);
                        end
`endif
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign v         = v_q;

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Testbench for nibble_addsub_seq (W=16). Directed vectors with literal
// expectations, plus a behavioural model (plain signed/unsigned arithmetic)
// checked against the outputs on every cycle a result is presented.
module tb_nibble_addsub_seq;

    localparam int W = 16;
    localparam int LAT = W / 4 + 1;
    localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) <<< (W - 1));

`ifdef NIBBLE_ADDSUB_SEQ_SAT_EN
    localparam logic [W-1:0] OVF_POS_S = 16'h7FFF;
    localparam logic [W-1:0] OVF_NEG_S = 16'h8000;
`else
    localparam logic [W-1:0] OVF_POS_S = 16'h8000;
    localparam logic [W-1:0] OVF_NEG_S = 16'h7FFF;
`endif

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         v;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         v;

    int   n_tests;
    int   n_fail;
    int   cyc;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t pin_e;
    bit   busy;
    bit   head_seen;

    nibble_addsub_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .m         (m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .v         (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outcome from plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tm);
        exp_t   r;
        longint sa;
        longint sb;
        longint sr;
        sa = longint'($signed(ta));
        sb = longint'($signed(tbv));
        sr = tm ? (sa - sb) : (sa + sb);
        r.s = W'(sr);
        r.v = (sr > MAXS) || (sr < MINS);
        if (tm) r.cout = (ta >= tbv);
        else    r.cout = ((longint'(ta) + longint'(tbv)) >= (longint'(1) <<< W));
`ifdef NIBBLE_ADDSUB_SEQ_SAT_EN
        if (r.v) r.s = (sa < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        r.acc = 0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Per-cycle checker: in_ready against request occupancy, results against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy      = 1'b0;
            head_seen = 1'b0;
        end else begin
            chk1("in_ready_track", in_ready, !busy);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk1("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q[0];
                    if (!head_seen) begin
                        n_tests++;
                        if (cyc - mon_e.acc != LAT) begin
                            n_fail++;
                            $display("FAIL latency: got %0d expected %0d", cyc - mon_e.acc, LAT);
                        end
                        head_seen = 1'b1;
                    end
                    chk("model_s", s, mon_e.s);
                    chk1("model_cout", cout, mon_e.cout);
                    chk1("model_v", v, mon_e.v);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        head_seen = 1'b0;
                        busy      = 1'b0;
                    end
                end
            end else if (head_seen) begin
                chk1("out_valid_dropped", out_valid, 1'b1);
                head_seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                mon_e     = model(a, b, m);
                mon_e.acc = cyc + 1;
                exp_q.push_back(mon_e);
                busy = 1'b1;
            end
        end
    end

    // One request with literal expectations; stall>0 holds out_ready low that
    // many cycles in DONE while in_valid and operands keep changing.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tm,
                          input logic [W-1:0] es, input logic ec, input logic ev,
                          input int stall, input string nm);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk1({nm, "_ready_timeout"}, in_ready, 1'b1);
        a = ta; b = tbv; m = tm; in_valid = 1'b1;
        if (stall > 0) out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = (stall > 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            if (stall > 0) begin
                a = W'($urandom); b = W'($urandom); m = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk1({nm, "_valid_timeout"}, out_valid, 1'b1);
        chk({nm, "_s"}, s, es);
        chk1({nm, "_cout"}, cout, ec);
        chk1({nm, "_v"}, v, ev);
        for (int i = 0; i < stall; i++) begin
            a = W'($urandom); b = W'($urandom); m = 1'($urandom);
            @(posedge clk); #1;
            chk({nm, "_hold_s"}, s, es);
            chk1({nm, "_hold_cout"}, cout, ec);
            chk1({nm, "_hold_v"}, v, ev);
            chk1({nm, "_hold_in_ready"}, in_ready, 1'b0);
            chk1({nm, "_hold_out_valid"}, out_valid, 1'b1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        busy = 1'b0; head_seen = 1'b0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; m = 1'b0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_s", s, 16'h0000);
        chk1("reset_cout", cout, 1'b0);
        chk1("reset_v", v, 1'b0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("post_reset_in_ready", in_ready, 1'b1);

        pin_e = model(16'h1234, 16'h0FFF, 1'b0);
        chk("pin1_s", pin_e.s, 16'h2233); chk1("pin1_c", pin_e.cout, 1'b0); chk1("pin1_v", pin_e.v, 1'b0);
        pin_e = model(16'h7FFF, 16'h0001, 1'b0);
        chk("pin2_s", pin_e.s, OVF_POS_S); chk1("pin2_c", pin_e.cout, 1'b0); chk1("pin2_v", pin_e.v, 1'b1);
        pin_e = model(16'h0000, 16'h0001, 1'b1);
        chk("pin3_s", pin_e.s, 16'hFFFF); chk1("pin3_c", pin_e.cout, 1'b0); chk1("pin3_v", pin_e.v, 1'b0);
        pin_e = model(16'h8000, 16'h0001, 1'b1);
        chk("pin4_s", pin_e.s, OVF_NEG_S); chk1("pin4_c", pin_e.cout, 1'b1); chk1("pin4_v", pin_e.v, 1'b1);

        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0, "add_basic");
        run_op(16'h7FFF, 16'h0001, 1'b0, OVF_POS_S, 1'b0, 1'b1, 0, "add_ovf");
        run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b1, OVF_NEG_S, 1'b1, 1'b1, 0, "sub_ovf");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "add_wrap");
        run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 0, "sub_equal");
        run_op(16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, 3, "stall");
        run_op(16'h4321, 16'h1111, 1'b1, 16'h3210, 1'b1, 1'b0, 0, "after_stall");

        // Abort in the second RUN cycle.
        a = 16'h1111; b = 16'h2222; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_s", s, 16'h0000);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk1("abort_release_in_ready", in_ready, 1'b1);
        repeat (8) begin
            @(posedge clk); #1;
            chk1("abort_no_out_valid", out_valid, 1'b0);
        end

        run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0, "post_abort");

        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: got %0d expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
